// File: rtl/saturate_sub_accum.sv
// Signed A-B, saturated and accumulated per block of `count` samples.
// Latency: 2 cycles from the last sample's inValid to outValid. No backpressure.
module saturate_sub_accum #(
  parameter int AWIDTH   = 8,
  parameter int BWIDTH   = 8,
  parameter int SUMWIDTH = 8,
  parameter int CWIDTH   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inValid,
  input  logic [AWIDTH-1:0]   A,
  input  logic [BWIDTH-1:0]   B,
  input  logic [CWIDTH-1:0]   count,
  input  logic                clear,
  output logic                outValid,
  output logic [SUMWIDTH-1:0] SUM,
  output logic                diffSaturated,
  output logic                sumSaturated
);

  localparam int DW = ((AWIDTH > BWIDTH) ? AWIDTH : BWIDTH) + 1;
  localparam int XW = ((DW > SUMWIDTH) ? DW : SUMWIDTH) + 1;

  localparam logic signed [XW-1:0] DMAX = {{(XW-SUMWIDTH+1){1'b0}}, {(SUMWIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] DMIN = {{(XW-SUMWIDTH+1){1'b1}}, {(SUMWIDTH-1){1'b0}}};
  localparam logic [SUMWIDTH-1:0]  SMAX = {1'b0, {(SUMWIDTH-1){1'b1}}};
  localparam logic [SUMWIDTH-1:0]  SMIN = {1'b1, {(SUMWIDTH-1){1'b0}}};

  typedef struct packed {
    logic                vld;
    logic                sat;
    logic [SUMWIDTH-1:0] dat;
  } s1_t;

  typedef enum logic {EMPTY, ACCUM} state_t;

  // ---------------- stage 0: full-width difference and clamp
  logic signed [XW-1:0] a_x, b_x, diff_x;
  logic [SUMWIDTH-1:0]  diff_sat;
  logic                 diff_flag;

  assign a_x    = {{(XW-AWIDTH){A[AWIDTH-1]}}, A};
  assign b_x    = {{(XW-BWIDTH){B[BWIDTH-1]}}, B};
  assign diff_x = a_x - b_x;

  always_comb begin
    diff_sat  = diff_x[SUMWIDTH-1:0];
    diff_flag = 1'b0;
    if (diff_x > DMAX) begin
      diff_sat  = SMAX;
      diff_flag = 1'b1;
    end else if (diff_x < DMIN) begin
      diff_sat  = SMIN;
      diff_flag = 1'b1;
    end
  end

  // ---------------- stage 1 register; clear drops the incoming sample
  s1_t s1_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      s1_q <= '0;
    end else begin
      s1_q.vld <= inValid;
      s1_q.sat <= diff_flag;
      s1_q.dat <= diff_sat;
    end
  end

  // ---------------- stage 2: saturating accumulate, block control
  state_t              state_q, state_n;
  logic [SUMWIDTH-1:0] acc_q, acc_n;
  logic [CWIDTH-1:0]   cnt_q, cnt_n, tgt_q, tgt_n;
  logic                dstk_q, dstk_n, sstk_q, sstk_n;
  logic                done;
  logic [SUMWIDTH-1:0] done_sum;
  logic                done_ds, done_ss;

  logic [SUMWIDTH:0]   step_x;
  logic                step_ovf;
  logic [SUMWIDTH-1:0] step_sat;

  // One guard bit is enough: the sum of two SUMWIDTH values cannot overflow SUMWIDTH+1.
  assign step_x   = {acc_q[SUMWIDTH-1], acc_q} + {s1_q.dat[SUMWIDTH-1], s1_q.dat};
  assign step_ovf = step_x[SUMWIDTH] ^ step_x[SUMWIDTH-1];
  assign step_sat = step_ovf ? (step_x[SUMWIDTH] ? SMIN : SMAX) : step_x[SUMWIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n  = state_q;
    acc_n    = acc_q;
    cnt_n    = cnt_q;
    tgt_n    = tgt_q;
    dstk_n   = dstk_q;
    sstk_n   = sstk_q;
    done     = 1'b0;
    done_sum = '0;
    done_ds  = 1'b0;
    done_ss  = 1'b0;

    if (clear) begin
      state_n = EMPTY;
      acc_n   = '0;
      cnt_n   = '0;
      dstk_n  = 1'b0;
      sstk_n  = 1'b0;
    end else if (s1_q.vld) begin
      case (state_q)
        EMPTY: begin
          tgt_n   = (count == '0) ? CWIDTH'(1) : count;
          acc_n   = s1_q.dat;
          cnt_n   = CWIDTH'(1);
          dstk_n  = s1_q.sat;
          sstk_n  = 1'b0;
          state_n = ACCUM;
        end
        ACCUM: begin
          acc_n  = step_sat;
          // cnt_q < tgt_q here, so the increment stays within CWIDTH
          cnt_n  = cnt_q + CWIDTH'(1);
          dstk_n = dstk_q | s1_q.sat;
          sstk_n = sstk_q | step_ovf;
        end
        default: state_n = EMPTY;
      endcase

      if (cnt_n == tgt_n) begin
        done     = 1'b1;
        done_sum = acc_n;
        done_ds  = dstk_n;
        done_ss  = sstk_n;
        state_n  = EMPTY;
        acc_n    = '0;
        cnt_n    = '0;
        dstk_n   = 1'b0;
        sstk_n   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q         <= '0;
      cnt_q         <= '0;
      tgt_q         <= '0;
      dstk_q        <= 1'b0;
      sstk_q        <= 1'b0;
      outValid      <= 1'b0;
      SUM           <= '0;
      diffSaturated <= 1'b0;
      sumSaturated  <= 1'b0;
    end else begin
      acc_q    <= acc_n;
      cnt_q    <= cnt_n;
      tgt_q    <= tgt_n;
      dstk_q   <= dstk_n;
      sstk_q   <= sstk_n;
      outValid <= done;
      if (done) begin
        SUM           <= done_sum;
        diffSaturated <= done_ds;
        sumSaturated  <= done_ss;
      end
    end
  end

endmodule

// File: tb/tb_saturate_sub_accum.sv
// Randomized and directed bench for saturate_sub_accum against an integer block model.
module tb_saturate_sub_accum;
  localparam int SW = 8;

  logic       clk = 1'b0;
  logic       reset, inValid, clear;
  logic [7:0] A, B, count;
  logic       outValid, diffSaturated, sumSaturated;
  logic [7:0] SUM;

  saturate_sub_accum #(.AWIDTH(8), .BWIDTH(8), .SUMWIDTH(8), .CWIDTH(8)) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .A(A), .B(B), .count(count),
    .clear(clear), .outValid(outValid), .SUM(SUM),
    .diffSaturated(diffSaturated), .sumSaturated(sumSaturated)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int sum; int ds; int ss; int c;} blk_t;
  blk_t obs_q[$];

  function automatic int sat(input int v);
    int lo, hi;
    lo = -(1 << (SW - 1));
    hi = (1 << (SW - 1)) - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model: pending sample, then block accumulation
  bit p_vld, p_ds, m_act, m_ds, m_ss;
  int p_diff, m_acc, m_n, m_tgt, d, t;
  bit e_ov, e_ds, e_ss;
  int e_sum;

  always @(posedge clk) begin
    if (reset) begin
      p_vld = 0; m_act = 0; m_acc = 0; m_n = 0; m_ds = 0; m_ss = 0;
      e_ov = 0; e_sum = 0; e_ds = 0; e_ss = 0;
    end else begin
      e_ov = 0;
      if (clear) begin
        p_vld = 0; m_act = 0; m_acc = 0; m_n = 0; m_ds = 0; m_ss = 0;
      end else begin
        if (p_vld) begin
          if (!m_act) begin
            m_tgt = (count == 0) ? 1 : int'(count);
            m_acc = p_diff; m_n = 1; m_ds = p_ds; m_ss = 0; m_act = 1;
          end else begin
            t = m_acc + p_diff;
            if (sat(t) != t) m_ss = 1;
            m_acc = sat(t);
            m_ds = m_ds | p_ds;
            m_n++;
          end
          if (m_n == m_tgt) begin
            e_ov = 1; e_sum = m_acc; e_ds = m_ds; e_ss = m_ss; m_act = 0;
          end
        end
        p_vld  = inValid;
        d      = int'($signed(A)) - int'($signed(B));
        p_diff = sat(d);
        p_ds   = (p_diff != d);
      end
    end
  end

  // ---------------- per-cycle compare
  always @(negedge clk) begin
    if (chk_en) begin
      chk("outValid", int'(outValid), int'(e_ov));
      chk("SUM", int'($signed(SUM)), e_sum);
      chk("diffSaturated", int'(diffSaturated), int'(e_ds));
      chk("sumSaturated", int'(sumSaturated), int'(e_ss));
    end
    if (outValid) obs_q.push_back('{int'($signed(SUM)), int'(diffSaturated), int'(sumSaturated), cyc});
  end

  // ---------------- stimulus helpers
  task automatic drive(input bit v, input int a, input int b, input int c, input bit clr);
    inValid = v; A = a[7:0]; B = b[7:0]; count = c[7:0]; clear = clr;
    if (v) last_cyc = cyc;
    @(posedge clk); #1;
    inValid = 1'b0; clear = 1'b0;
  endtask

  task automatic idle(input int n);
    inValid = 1'b0; clear = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_blk(input string name, input int idx, input int s, input int ds, input int ss);
    if (idx < obs_q.size()) begin
      chk({name, " SUM"}, obs_q[idx].sum, s);
      chk({name, " diffSat"}, obs_q[idx].ds, ds);
      chk({name, " sumSat"}, obs_q[idx].ss, ss);
    end else begin
      tests++; fails++;
      $display("FAIL %s: block %0d missing, only %0d seen", name, idx, obs_q.size());
    end
  endtask

  initial begin
    reset = 1'b1; inValid = 1'b0; clear = 1'b0; A = '0; B = '0; count = 8'd4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outValid", int'(outValid), 0);
    chk("reset SUM", int'($signed(SUM)), 0);
    chk("reset diffSat", int'(diffSaturated), 0);
    chk("reset sumSat", int'(sumSaturated), 0);
    chk_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    // four samples of 10-3 into a block of 4
    obs_q.delete();
    for (int i = 0; i < 4; i++) drive(1, 10, 3, 4, 0);
    idle(5);
    chk("basic nblk", obs_q.size(), 1);
    check_blk("basic", 0, 28, 0, 0);
    if (obs_q.size() > 0) chk("basic latency", obs_q[0].c - last_cyc, 2);

    // single-sample blocks with clamped differences
    obs_q.delete();
    drive(1, 100, -100, 1, 0);
    drive(1, -128, 127, 1, 0);
    idle(4);
    chk("dsat nblk", obs_q.size(), 2);
    check_blk("dsat pos", 0, 127, 1, 0);
    check_blk("dsat neg", 1, -128, 1, 0);

    // per-step accumulation clamp
    obs_q.delete();
    drive(1, 100, 0, 3, 0);
    drive(1, 100, 0, 3, 0);
    drive(1, -50, 0, 3, 0);
    idle(4);
    chk("ssat nblk", obs_q.size(), 1);
    check_blk("ssat", 0, 77, 0, 1);

    // clear mid-block with a simultaneous sample
    obs_q.delete();
    drive(1, 5, 0, 4, 0);
    drive(1, 5, 0, 4, 0);
    drive(1, 5, 0, 4, 1);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 4, 0);
    idle(4);
    chk("clear nblk", obs_q.size(), 1);
    check_blk("clear", 0, 4, 0, 0);

    // count=0 streams one block per cycle
    obs_q.delete();
    for (int i = 0; i < 4; i++) drive(1, 2, 0, 0, 0);
    idle(4);
    chk("cnt0 nblk", obs_q.size(), 4);
    for (int i = 0; i < 4; i++) check_blk("cnt0", i, 2, 0, 0);

    // count changes 1->3 mid-stream; it only takes hold at a block start
    obs_q.delete();
    for (int i = 0; i < 7; i++) drive(1, 2, 0, (i < 2) ? 1 : 3, 0);
    idle(4);
    chk("cntchg nblk", obs_q.size(), 3);
    check_blk("cntchg b0", 0, 2, 0, 0);
    check_blk("cntchg b1", 1, 6, 0, 0);
    check_blk("cntchg b2", 2, 6, 0, 0);

    // reset mid-block
    obs_q.delete();
    drive(1, 1, 0, 4, 0);
    drive(1, 1, 0, 4, 0);
    reset = 1'b1;
    idle(2);
    @(negedge clk);
    chk("rst mid SUM", int'($signed(SUM)), 0);
    chk("rst mid outValid", int'(outValid), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst mid nblk", obs_q.size(), 0);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 4, 0);
    idle(4);
    chk("rst after nblk", obs_q.size(), 1);
    check_blk("rst after", 0, 4, 0, 0);

    // randomized traffic, checked every cycle by the model
    count = 8'd3;
    for (int i = 0; i < 4000; i++) begin
      int c;
      c = int'(count);
      if ($urandom_range(19) == 0) begin
        case ($urandom_range(7))
          0: c = 0;
          1: c = 1;
          2: c = 2;
          3: c = 3;
          4: c = 4;
          5: c = 7;
          6: c = 255;
          default: c = 5;
        endcase
      end
      reset = ($urandom_range(299) == 0);
      drive($urandom_range(9) < 7, int'($urandom_range(255)), int'($urandom_range(255)),
            c, $urandom_range(39) == 0);
    end
    reset = 1'b0;
    idle(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
